// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory port between instruction fetch and load/store.
// Grants one access per cycle, aligns store lanes, extends load data and registers responses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [15:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_unsigned,
    input  logic [15:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic [3:0]  mem_w_en,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned CNT_W =
        ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_starved;
    logic             w_if_gnt;
    logic             w_ls_gnt;
    logic             w_if_err;
    logic             w_ls_legal;
    logic [1:0]       w_lane;
    logic [3:0]       w_base_mask;
    logic [31:0]      w_shift_rd;
    logic [31:0]      w_load_ext;

    logic             r_if_rsp_valid;
    logic [31:0]      r_if_rsp_data;
    logic             r_if_rsp_err;
    logic             r_ls_rsp_valid;
    logic [31:0]      r_ls_rsp_data;
    logic             r_ls_rsp_err;

    // Load/store wins unless fetch is alone or has been passed over STARVE_LIMIT times
    assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_if_gnt     = ~rst & if_req_valid & (~ls_req_valid | w_starved);
    assign w_ls_gnt     = ~rst & ls_req_valid & ~w_if_gnt;
    assign if_req_ready = w_if_gnt;
    assign ls_req_ready = w_ls_gnt;

    assign w_if_err   = (if_req_addr[1:0] != 2'b00);
    assign w_lane     = ls_req_addr[1:0];
    assign w_shift_rd = mem_rdata >> {w_lane, 3'b000};

    always_comb begin
        w_ls_legal  = 1'b0;
        w_base_mask = 4'b1111;
        case (ls_req_size)
            2'b00: begin
                w_ls_legal  = 1'b1;
                w_base_mask = 4'b0001;
            end
            2'b01: begin
                w_ls_legal  = ~ls_req_addr[0];
                w_base_mask = 4'b0011;
            end
            2'b10: w_ls_legal = (ls_req_addr[1:0] == 2'b00);
            default: w_ls_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_load_ext = w_shift_rd;
        case (ls_req_size)
            2'b00:   w_load_ext = {{24{w_shift_rd[7] & ~ls_req_unsigned}}, w_shift_rd[7:0]};
            2'b01:   w_load_ext = {{16{w_shift_rd[15] & ~ls_req_unsigned}}, w_shift_rd[15:0]};
            default: w_load_ext = w_shift_rd;
        endcase
    end

    // Memory port drive; rejected accesses leave the port idle
    always_comb begin
        mem_w_en  = 4'b0000;
        mem_addr  = 16'h0000;
        mem_wdata = 32'h0000_0000;
        if (w_if_gnt && !w_if_err) begin
            mem_addr = if_req_addr;
        end else if (w_ls_gnt && w_ls_legal) begin
            mem_addr = {ls_req_addr[15:2], 2'b00};
            if (ls_req_we) begin
                mem_w_en  = w_base_mask << w_lane;
                mem_wdata = ls_req_wdata << {w_lane, 3'b000};
            end
        end
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req_valid || w_if_gnt) begin
            w_starve_nxt = '0;
        end else if (w_ls_gnt && !w_starved) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt   <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= 32'h0000_0000;
            r_if_rsp_err   <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_ls_rsp_data  <= 32'h0000_0000;
            r_ls_rsp_err   <= 1'b0;
        end else begin
            r_starve_cnt   <= w_starve_nxt;
            r_if_rsp_valid <= w_if_gnt;
            r_ls_rsp_valid <= w_ls_gnt;
            if (w_if_gnt) begin
                r_if_rsp_err  <= w_if_err;
                r_if_rsp_data <= w_if_err ? 32'h0000_0000 : mem_rdata;
            end
            if (w_ls_gnt) begin
                r_ls_rsp_err  <= ~w_ls_legal;
                r_ls_rsp_data <= (w_ls_legal && !ls_req_we) ? w_load_ext : 32'h0000_0000;
            end
        end
    end

    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;
    assign if_rsp_err   = r_if_rsp_err;
    assign ls_rsp_valid = r_ls_rsp_valid;
    assign ls_rsp_data  = r_ls_rsp_data;
    assign ls_rsp_err   = r_ls_rsp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// byte-level reference memory and a grant model based on how long fetch has been passed over.
module tb_mem_port_arbiter;
    localparam int unsigned STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [15:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_we;
    logic [1:0]  ls_req_size;
    logic        ls_req_unsigned;
    logic [15:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_size(ls_req_size),
        .ls_req_unsigned(ls_req_unsigned), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory attached to the port: reloads its pattern while reset is held
    logic [31:0] mem_words [0:255];
    assign mem_rdata = mem_words[mem_addr[9:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_words[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_w_en[b]) mem_words[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [0:1023];
    int         waited;

    typedef struct packed {
        logic        if_gnt;
        logic        ls_gnt;
        logic [3:0]  w_en;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        if_err;
        logic [31:0] if_data;
        logic        ls_err;
        logic [31:0] ls_data;
    } exp_t;

    task automatic ref_init();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        waited = 0;
    endtask

    function automatic exp_t model_predict();
        exp_t        e;
        int          n;
        int          al;
        int          mask;
        logic [31:0] v;
        e  = '0;
        e.if_gnt = if_req_valid && (!ls_req_valid || waited >= int'(STARVE_LIMIT));
        e.ls_gnt = ls_req_valid && !e.if_gnt;
        if (e.if_gnt) begin
            e.if_err = (int'(if_req_addr) % 4) != 0;
            if (!e.if_err) begin
                e.addr = if_req_addr;
                for (int i = 0; i < 4; i++) e.if_data[8*i +: 8] = ref_mem[int'(if_req_addr) + i];
            end
        end
        if (e.ls_gnt) begin
            n  = (ls_req_size == 2'd3) ? 0 : (1 << ls_req_size);
            al = int'(ls_req_addr) % 4;
            e.ls_err = (n == 0) || ((int'(ls_req_addr) % n) != 0);
            if (!e.ls_err) begin
                e.addr = 16'(int'(ls_req_addr) - al);
                if (ls_req_we) begin
                    mask    = ((1 << n) - 1) << al;
                    e.w_en  = 4'(mask);
                    e.wdata = ls_req_wdata << (8 * al);
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(ls_req_addr) + i];
                    if (!ls_req_unsigned && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                    e.ls_data = v;
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        if_req_valid = 1'b0; if_req_addr = 16'h0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_size = 2'd0;
        ls_req_unsigned = 1'b0; ls_req_addr = 16'h0; ls_req_wdata = 32'h0;
    endtask

    task automatic set_ls(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd);
        ls_req_valid = 1'b1; ls_req_we = we; ls_req_size = sz;
        ls_req_unsigned = uns; ls_req_addr = a; ls_req_wdata = wd;
    endtask

    task automatic set_if(input logic [15:0] a);
        if_req_valid = 1'b1; if_req_addr = a;
    endtask

    task automatic test_reset();
        set_if(16'h0004);
        set_ls(1'b1, 2'd2, 1'b0, 16'h0010, 32'hFFFF_FFFF);
        #1;
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b exp 0", if_req_ready); end
        checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ls_ready got %b exp 0", ls_req_ready); end
        checks++; if (mem_w_en !== 4'b0000) begin errors++; $display("FAIL reset_w_en got %b exp 0000", mem_w_en); end
        checks++;
        if ({if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err} !== 4'b0000 ||
            if_rsp_data !== 32'h0 || ls_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp got ifv=%b ife=%b ifd=%h lsv=%b lse=%b lsd=%h exp all 0",
                     if_rsp_valid, if_rsp_err, if_rsp_data, ls_rsp_valid, ls_rsp_err, ls_rsp_data);
        end
        set_idle();
        rst = 1'b0;
        ref_init();
        tick();
    endtask

    task automatic test_fetch();
        set_ls(1'b1, 2'd2, 1'b0, 16'h0004, 32'hDEAD_BEEF);
        tick();
        set_idle();
        set_if(16'h0004);
        #1;
        checks++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready got if=%b ls=%b exp 1/0", if_req_ready, ls_req_ready); end
        checks++; if (mem_addr !== 16'h0004 || mem_w_en !== 4'b0) begin errors++; $display("FAIL fetch_port got addr=%h wen=%b exp 0004/0000", mem_addr, mem_w_en); end
        tick();
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEAD_BEEF || if_rsp_err !== 1'b0) begin
            errors++; $display("FAIL fetch_rsp got v=%b d=%h e=%b exp 1/deadbeef/0", if_rsp_valid, if_rsp_data, if_rsp_err);
        end
        set_if(16'h0006);
        #1;
        checks++; if (if_req_ready !== 1'b1 || mem_addr !== 16'h0 || mem_w_en !== 4'b0) begin errors++; $display("FAIL fetch_unaligned_port got rdy=%b addr=%h wen=%b exp 1/0000/0000", if_req_ready, mem_addr, mem_w_en); end
        tick();
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0 || if_rsp_err !== 1'b1) begin
            errors++; $display("FAIL fetch_unaligned_rsp got v=%b d=%h e=%b exp 1/0/1", if_rsp_valid, if_rsp_data, if_rsp_err);
        end
        set_idle();
        tick();
        checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", if_rsp_valid); end
    endtask

    task automatic test_byte();
        set_ls(1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_00A5);
        #1;
        checks++;
        if (mem_w_en !== 4'b1000 || mem_addr !== 16'h0010 || mem_wdata !== 32'hA500_0000) begin
            errors++; $display("FAIL sb_port got wen=%b addr=%h wd=%h exp 1000/0010/a5000000", mem_w_en, mem_addr, mem_wdata);
        end
        tick();
        checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h0 || ls_rsp_err !== 1'b0) begin errors++; $display("FAIL sb_rsp got v=%b d=%h e=%b exp 1/0/0", ls_rsp_valid, ls_rsp_data, ls_rsp_err); end
        set_ls(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
        tick();
        checks++; if (ls_rsp_data !== 32'hFFFF_FFA5 || ls_rsp_err !== 1'b0) begin errors++; $display("FAIL lb got %h exp ffffffa5", ls_rsp_data); end
        set_ls(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
        tick();
        checks++; if (ls_rsp_data !== 32'h0000_00A5) begin errors++; $display("FAIL lbu got %h exp 000000a5", ls_rsp_data); end
        set_idle();
        tick();
    endtask

    task automatic test_half();
        set_ls(1'b1, 2'd1, 1'b0, 16'h0022, 32'h0000_8001);
        #1;
        checks++; if (mem_w_en !== 4'b1100 || mem_wdata !== 32'h8001_0000) begin errors++; $display("FAIL sh_port got wen=%b wd=%h exp 1100/80010000", mem_w_en, mem_wdata); end
        tick();
        set_ls(1'b0, 2'd1, 1'b0, 16'h0022, 32'h0);
        tick();
        checks++; if (ls_rsp_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h exp ffff8001", ls_rsp_data); end
        set_ls(1'b0, 2'd2, 1'b0, 16'h0023, 32'h0);
        #1;
        checks++; if (ls_req_ready !== 1'b1 || mem_w_en !== 4'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL lw_misaligned_port got rdy=%b wen=%b addr=%h exp 1/0000/0000", ls_req_ready, mem_w_en, mem_addr); end
        tick();
        checks++; if (ls_rsp_valid !== 1'b1 || ls_rsp_err !== 1'b1 || ls_rsp_data !== 32'h0) begin errors++; $display("FAIL lw_misaligned_rsp got v=%b e=%b d=%h exp 1/1/0", ls_rsp_valid, ls_rsp_err, ls_rsp_data); end
        set_idle();
        tick();
    endtask

    task automatic test_store_load();
        set_ls(1'b1, 2'd2, 1'b0, 16'h0040, 32'h1234_5678);
        tick();
        set_ls(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);
        tick();
        checks++; if (ls_rsp_data !== 32'h1234_5678 || ls_rsp_err !== 1'b0) begin errors++; $display("FAIL sw_lw got %h exp 12345678", ls_rsp_data); end
        set_ls(1'b1, 2'd3, 1'b0, 16'h0040, 32'hFFFF_FFFF);
        #1;
        checks++; if (ls_req_ready !== 1'b1 || mem_w_en !== 4'b0000) begin errors++; $display("FAIL size11_port got rdy=%b wen=%b exp 1/0000", ls_req_ready, mem_w_en); end
        tick();
        checks++; if (ls_rsp_err !== 1'b1 || ls_rsp_data !== 32'h0) begin errors++; $display("FAIL size11_rsp got e=%b d=%h exp 1/0", ls_rsp_err, ls_rsp_data); end
        set_ls(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);
        tick();
        checks++; if (ls_rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL size11_nowrite got %h exp 12345678", ls_rsp_data); end
        set_idle();
        tick();
    endtask

    task automatic test_starve();
        logic exp_if;
        set_if(16'h0008);
        set_ls(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_if = ((k % 4) == 3);
            checks++;
            if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin
                errors++; $display("FAIL starve_seq[%0d] got if=%b ls=%b exp if=%b", k, if_req_ready, ls_req_ready, exp_if);
            end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        set_if(16'h0008);
        set_ls(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);
        tick();
        tick();
        #1;
        checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b exp 1", ls_req_ready); end
        @(posedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ls_rsp_valid !== 1'b0 || ls_req_ready !== 1'b0 || if_req_ready !== 1'b0) begin
                errors++; $display("FAIL midrst_hold[%0d] got rspv=%b lsr=%b ifr=%b exp 0/0/0", k, ls_rsp_valid, ls_req_ready, if_req_ready);
            end
            tick();
        end
        rst = 1'b0;
        ref_init();
        #1;
        checks++; if (ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_release got %b exp 0", ls_rsp_valid); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (if_req_ready !== (k == 3) || ls_req_ready !== (k != 3)) begin
                errors++; $display("FAIL midrst_seq[%0d] got if=%b ls=%b", k, if_req_ready, ls_req_ready);
            end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        logic pending;
        rst = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        ref_init();
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_req_addr  = 16'($urandom_range(0, 1023));
                if ($urandom_range(0, 4) != 0) if_req_addr[1:0] = 2'b00;
            end
            ls_req_valid    = ($urandom_range(0, 1) == 1);
            ls_req_we       = ($urandom_range(0, 1) == 1);
            ls_req_size     = 2'($urandom_range(0, 3));
            ls_req_unsigned = ($urandom_range(0, 1) == 1);
            ls_req_addr     = 16'($urandom_range(0, 1023));
            ls_req_wdata    = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (ls_req_size == 2'd1) ls_req_addr[0] = 1'b0;
                if (ls_req_size == 2'd2) ls_req_addr[1:0] = 2'b00;
            end
            #1;
            e = model_predict();
            checks++;
            if (if_req_ready !== e.if_gnt || ls_req_ready !== e.ls_gnt) begin
                errors++; $display("FAIL rnd_grant[%0d] got if=%b ls=%b exp if=%b ls=%b", c, if_req_ready, ls_req_ready, e.if_gnt, e.ls_gnt);
            end
            checks++;
            if (mem_w_en !== e.w_en || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                errors++; $display("FAIL rnd_port[%0d] got wen=%b addr=%h wd=%h exp wen=%b addr=%h wd=%h",
                                   c, mem_w_en, mem_addr, mem_wdata, e.w_en, e.addr, e.wdata);
            end
            tick();
            checks++;
            if (if_rsp_valid !== e.if_gnt || ls_rsp_valid !== e.ls_gnt) begin
                errors++; $display("FAIL rnd_rspv[%0d] got if=%b ls=%b exp if=%b ls=%b", c, if_rsp_valid, ls_rsp_valid, e.if_gnt, e.ls_gnt);
            end
            if (e.if_gnt) begin
                checks++;
                if (if_rsp_data !== e.if_data || if_rsp_err !== e.if_err) begin
                    errors++; $display("FAIL rnd_if_rsp[%0d] got d=%h e=%b exp d=%h e=%b", c, if_rsp_data, if_rsp_err, e.if_data, e.if_err);
                end
            end
            if (e.ls_gnt) begin
                checks++;
                if (ls_rsp_data !== e.ls_data || ls_rsp_err !== e.ls_err) begin
                    errors++; $display("FAIL rnd_ls_rsp[%0d] got d=%h e=%b exp d=%h e=%b", c, ls_rsp_data, ls_rsp_err, e.ls_data, e.ls_err);
                end
                if (ls_req_we && !e.ls_err)
                    for (int i = 0; i < (1 << ls_req_size); i++)
                        ref_mem[int'(ls_req_addr) + i] = ls_req_wdata[8*i +: 8];
            end
            if (!if_req_valid || e.if_gnt) waited = 0;
            else if (e.ls_gnt) waited++;
            pending = if_req_valid && !e.if_gnt;
        end
        set_idle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_byte();
        test_half();
        test_store_load();
        test_starve();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
